// File: rtl/rggen_wishbone_master_bridge.sv
// rggen_wishbone_master_bridge
// Issues single rggen-style register accesses as Wishbone B4 pipelined cycles.
// Only one cycle is outstanding at a time. A retry termination reissues the same
// request after a one-cycle gap, up to MAX_RETRY times, before reporting SLVERR.
// All outputs come straight from flops.
// Optional watchdog: define RGGEN_WB_MASTER_TIMEOUT_EN to abort a cycle that has
// been open for TIMEOUT_CYCLES clocks without a termination (status 2'b11).
// Without the macro the bridge waits indefinitely for a termination.
module rggen_wishbone_master_bridge #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_bus_valid,
    input  logic [1:0]               i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
    input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
    output logic                     o_bus_ready,
    output logic [1:0]               o_bus_status,
    output logic [BUS_WIDTH-1:0]     o_bus_read_data,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    input  logic                     i_wb_stall,
    output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
    output logic                     o_wb_we,
    output logic [BUS_WIDTH-1:0]     o_wb_dat,
    output logic [BUS_WIDTH/8-1:0]   o_wb_sel,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,
    input  logic                     i_wb_rty,
    input  logic [BUS_WIDTH-1:0]     i_wb_dat
);

    localparam int         STRB_W     = BUS_WIDTH / 8;
    localparam int         RETRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [1:0] ST_OKAY    = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        STB,
        WAIT,
        GAP,
        RESP
    } state_e;

    state_e                   state_q, state_d;
    logic                     wb_cyc_q, wb_cyc_d;
    logic                     wb_stb_q, wb_stb_d;
    logic [ADDRESS_WIDTH-1:0] wb_adr_q, wb_adr_d;
    logic                     wb_we_q, wb_we_d;
    logic [BUS_WIDTH-1:0]     wb_dat_q, wb_dat_d;
    logic [STRB_W-1:0]        wb_sel_q, wb_sel_d;
    logic                     bus_ready_q, bus_ready_d;
    logic [1:0]               bus_status_q, bus_status_d;
    logic [BUS_WIDTH-1:0]     bus_read_data_q, bus_read_data_d;
    logic [RETRY_W-1:0]       retry_cnt_q, retry_cnt_d;

    logic tmo_expired;
    logic sample_term;
    logic term_seen;
    logic cycle_open;

`ifdef RGGEN_WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog count: cleared while idle or in the retry gap, counts open-cycle clocks, saturates.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE || state_q == GAP) begin
            tmo_cnt_d = '0;
        end else if (wb_cyc_q && tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Watchdog count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The current clock is the TIMEOUT_CYCLES-th with cyc high; abort at its closing edge.
    assign tmo_expired = wb_cyc_q && (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: never expires (the limit is a positive count).
    assign tmo_expired = (TIMEOUT_CYCLES < 0);
`endif

    assign cycle_open = (state_q == STB) || (state_q == WAIT);
    assign term_seen  = sample_term && (i_wb_err || i_wb_ack || i_wb_rty);

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d         = state_q;
        wb_cyc_d        = wb_cyc_q;
        wb_stb_d        = wb_stb_q;
        wb_adr_d        = wb_adr_q;
        wb_we_d         = wb_we_q;
        wb_dat_d        = wb_dat_q;
        wb_sel_d        = wb_sel_q;
        bus_ready_d     = 1'b0;
        bus_status_d    = bus_status_q;
        bus_read_data_d = bus_read_data_q;
        retry_cnt_d     = retry_cnt_q;
        sample_term     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_bus_valid) begin
                    if (i_bus_access[1]) begin
                        wb_adr_d = i_bus_address;
                        wb_we_d  = i_bus_access[0];
                        wb_dat_d = i_bus_write_data;
                        wb_sel_d = i_bus_strobe;
                        wb_cyc_d = 1'b1;
                        wb_stb_d = 1'b1;
                        state_d  = STB;
                    end else begin
                        // Not a real access: complete it with an error without touching the bus.
                        bus_status_d    = ST_SLVERR;
                        bus_read_data_d = '0;
                        state_d         = RESP;
                    end
                end
            end
            STB:     sample_term = !i_wb_stall;
            WAIT:    sample_term = 1'b1;
            GAP: begin
                wb_cyc_d = 1'b1;
                wb_stb_d = 1'b1;
                state_d  = STB;
            end
            RESP: begin
                bus_ready_d = 1'b1;
                retry_cnt_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (term_seen) begin
            wb_cyc_d = 1'b0;
            wb_stb_d = 1'b0;
            if (i_wb_err) begin
                bus_status_d    = ST_SLVERR;
                bus_read_data_d = '0;
                state_d         = RESP;
            end else if (i_wb_ack) begin
                bus_status_d    = ST_OKAY;
                bus_read_data_d = wb_we_q ? '0 : i_wb_dat;
                state_d         = RESP;
            end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                state_d     = GAP;
            end else begin
                bus_status_d    = ST_SLVERR;
                bus_read_data_d = '0;
                state_d         = RESP;
            end
        end else if (cycle_open && tmo_expired) begin
            wb_cyc_d        = 1'b0;
            wb_stb_d        = 1'b0;
            bus_status_d    = ST_TIMEOUT;
            bus_read_data_d = '0;
            state_d         = RESP;
        end else if (sample_term && state_q == STB) begin
            wb_stb_d = 1'b0;
            state_d  = WAIT;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            wb_cyc_q        <= 1'b0;
            wb_stb_q        <= 1'b0;
            wb_adr_q        <= '0;
            wb_we_q         <= 1'b0;
            wb_dat_q        <= '0;
            wb_sel_q        <= '0;
            bus_ready_q     <= 1'b0;
            bus_status_q    <= 2'b00;
            bus_read_data_q <= '0;
            retry_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            wb_cyc_q        <= wb_cyc_d;
            wb_stb_q        <= wb_stb_d;
            wb_adr_q        <= wb_adr_d;
            wb_we_q         <= wb_we_d;
            wb_dat_q        <= wb_dat_d;
            wb_sel_q        <= wb_sel_d;
            bus_ready_q     <= bus_ready_d;
            bus_status_q    <= bus_status_d;
            bus_read_data_q <= bus_read_data_d;
            retry_cnt_q     <= retry_cnt_d;
        end
    end

    assign o_wb_cyc        = wb_cyc_q;
    assign o_wb_stb        = wb_stb_q;
    assign o_wb_adr        = wb_adr_q;
    assign o_wb_we         = wb_we_q;
    assign o_wb_dat        = wb_dat_q;
    assign o_wb_sel        = wb_sel_q;
    assign o_bus_ready     = bus_ready_q;
    assign o_bus_status    = bus_status_q;
    assign o_bus_read_data = bus_read_data_q;

endmodule

// File: tb/tb_rggen_wishbone_master_bridge.sv
// Testbench for rggen_wishbone_master_bridge: directed transactions against a
// scripted Wishbone slave; completions are checked by a scoreboard monitor.
module tb_rggen_wishbone_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_bus_valid = 1'b0;
    logic [1:0]    i_bus_access = 2'b00;
    logic [AW-1:0] i_bus_address = '0;
    logic [DW-1:0] i_bus_write_data = '0;
    logic [SW-1:0] i_bus_strobe = '0;
    logic          o_bus_ready;
    logic [1:0]    o_bus_status;
    logic [DW-1:0] o_bus_read_data;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          i_wb_stall = 1'b0;
    logic [AW-1:0] o_wb_adr;
    logic          o_wb_we;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_err = 1'b0;
    logic          i_wb_rty = 1'b0;
    logic [DW-1:0] i_wb_dat = '0;

    always #5 i_clk = ~i_clk;

    rggen_wishbone_master_bridge #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (DW),
        .MAX_RETRY     (3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_bus_valid     (i_bus_valid),
        .i_bus_access    (i_bus_access),
        .i_bus_address   (i_bus_address),
        .i_bus_write_data(i_bus_write_data),
        .i_bus_strobe    (i_bus_strobe),
        .o_bus_ready     (o_bus_ready),
        .o_bus_status    (o_bus_status),
        .o_bus_read_data (o_bus_read_data),
        .o_wb_cyc        (o_wb_cyc),
        .o_wb_stb        (o_wb_stb),
        .i_wb_stall      (i_wb_stall),
        .o_wb_adr        (o_wb_adr),
        .o_wb_we         (o_wb_we),
        .o_wb_dat        (o_wb_dat),
        .o_wb_sel        (o_wb_sel),
        .i_wb_ack        (i_wb_ack),
        .i_wb_err        (i_wb_err),
        .i_wb_rty        (i_wb_rty),
        .i_wb_dat        (i_wb_dat)
    );

    typedef struct packed {
        logic [1:0]    status;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ready_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completion pulse pops and compares one expectation.
    always @(negedge i_clk) begin : monitor
        resp_t e;
        if (i_rst_n && o_bus_ready) begin
            ready_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready actual status=%b data=%h expected no completion",
                         o_bus_status, o_bus_read_data);
            end else begin
                e = exp_q.pop_front();
                if (o_bus_status !== e.status || o_bus_read_data !== e.data) begin
                    errors++;
                    $display("FAIL response actual status=%b data=%h expected status=%b data=%h",
                             o_bus_status, o_bus_read_data, e.status, e.data);
                end
            end
        end
    end

    // term: 0 = ack, 1 = err and ack together, 2 = never terminate.
    // resp_at: the slave terminates only once cyc has been high for at least this many clocks.
    task automatic run_txn(
        input string         name,
        input logic          we,
        input logic [AW-1:0] addr,
        input logic [DW-1:0] wdata,
        input logic [SW-1:0] strb,
        input int            stalls,
        input int            n_rty,
        input int            term,
        input int            resp_at,
        input logic [DW-1:0] rdat,
        input logic [1:0]    exp_st,
        input logic [DW-1:0] exp_rd,
        input int            exp_stb_cycles,
        input int            exp_reissue,
        input int            exp_cyc,
        input int            exp_lat
    );
        resp_t e;
        int    budget = 200;
        int    n_neg = 0;
        int    stb_cycles = 0;
        int    cyc_cycles = 0;
        int    reissues = 0;
        int    gap_total = 0;
        int    zero_run = 0;
        int    attempts = 0;
        int    stall_left = stalls;
        int    bad = 0;
        bit    pending = 0;
        bit    seen_cyc = 0;
        bit    prev_cyc = 0;
        bit    got_ready = 0;

        e.status = exp_st;
        e.data   = exp_rd;
        exp_q.push_back(e);

        @(negedge i_clk);
        i_bus_valid      = 1'b1;
        i_bus_access     = {1'b1, we};
        i_bus_address    = addr;
        i_bus_write_data = wdata;
        i_bus_strobe     = strb;

        while (!got_ready && budget > 0) begin
            @(negedge i_clk);
            budget--;
            n_neg++;
            i_wb_ack   = 1'b0;
            i_wb_err   = 1'b0;
            i_wb_rty   = 1'b0;
            i_wb_stall = 1'b0;
            if (o_bus_ready) begin
                got_ready   = 1;
                i_bus_valid = 1'b0;
            end
            if (o_wb_cyc) begin
                cyc_cycles++;
                if (!prev_cyc && seen_cyc) begin
                    reissues++;
                    gap_total += zero_run;
                end
                seen_cyc = 1;
                zero_run = 0;
            end else if (seen_cyc) begin
                zero_run++;
            end
            prev_cyc = o_wb_cyc;
            if (o_wb_stb) begin
                stb_cycles++;
                if (o_wb_adr !== addr || o_wb_we !== we || o_wb_dat !== wdata || o_wb_sel !== strb)
                    bad++;
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    pending = 1;
                end
            end else if (o_wb_cyc && pending && cyc_cycles >= resp_at) begin
                if (attempts < n_rty) begin
                    i_wb_rty = 1'b1;
                    attempts++;
                    pending  = 0;
                end else if (term == 0) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = rdat;
                    pending  = 0;
                end else if (term == 1) begin
                    i_wb_ack = 1'b1;
                    i_wb_err = 1'b1;
                    i_wb_dat = rdat;
                    pending  = 0;
                end
            end
        end
        i_bus_valid = 1'b0;

        check({name, "_ready_seen"}, 64'(got_ready), 64'd1);
        check({name, "_req_stable"}, 64'(bad), 64'd0);
        check({name, "_stb_cycles"}, 64'(stb_cycles), 64'(exp_stb_cycles));
        check({name, "_reissues"}, 64'(reissues), 64'(exp_reissue));
        check({name, "_gap_cycles"}, 64'(gap_total), 64'(exp_reissue));
        if (exp_cyc >= 0) check({name, "_cyc_cycles"}, 64'(cyc_cycles), 64'(exp_cyc));
        if (exp_lat >= 0) check({name, "_latency"}, 64'(n_neg - 1), 64'(exp_lat));

        @(negedge i_clk);
        check({name, "_ready_one_cycle"}, 64'(o_bus_ready), 64'd0);
        check({name, "_rdata_hold"}, 64'(o_bus_read_data), 64'(exp_rd));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int rc;

        repeat (3) @(negedge i_clk);
        check("rst_cyc", 64'(o_wb_cyc), 64'd0);
        check("rst_stb", 64'(o_wb_stb), 64'd0);
        check("rst_ready", 64'(o_bus_ready), 64'd0);
        check("rst_status_rdata", {30'd0, o_bus_status, o_bus_read_data}, 64'd0);
        check("rst_req_fields", {o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel}, 64'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        //      name        we    addr   wdata         strb  stl rty term at rdat          st     rd            stb rei cyc lat
        run_txn("rd_basic", 1'b0, 8'h10, 32'h0,        4'hF, 0, 0,  0,   0, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1,  0,  2,  3);
        run_txn("wr_stall", 1'b1, 8'h24, 32'h12345678, 4'h3, 4, 0,  0,   0, 32'hFFFFFFFF, 2'b00, 32'h0,        5,  0,  6,  7);
        run_txn("rd_rty3",  1'b0, 8'h30, 32'h0,        4'hF, 0, 3,  0,   0, 32'h000000A5, 2'b00, 32'h000000A5, 4,  3,  8,  12);
        run_txn("rd_rty4",  1'b0, 8'h34, 32'h0,        4'hF, 0, 4,  0,   0, 32'h000000A5, 2'b10, 32'h0,        4,  3,  8,  12);
        run_txn("err_ack",  1'b0, 8'h38, 32'h0,        4'hF, 0, 0,  1,   0, 32'h5555AAAA, 2'b10, 32'h0,        1,  0,  2,  3);
        run_txn("wr_stl1",  1'b1, 8'hFC, 32'hCAFEF00D, 4'hC, 1, 0,  0,   0, 32'h11111111, 2'b00, 32'h0,        2,  0,  3,  4);

        // Terminations while no cycle is open must be ignored.
        rc = ready_count;
        @(negedge i_clk);
        i_wb_dat = 32'h13572468;
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b1;
        @(negedge i_clk);
        i_wb_err = 1'b0;
        i_wb_rty = 1'b1;
        @(negedge i_clk);
        i_wb_rty = 1'b0;
        repeat (2) @(negedge i_clk);
        check("unsol_no_ready", 64'(ready_count), 64'(rc));
        check("unsol_cyc_low", 64'(o_wb_cyc), 64'd0);
        check("unsol_rdata_hold", 64'(o_bus_read_data), 64'd0);

        // Asynchronous reset while a cycle waits for its termination.
        i_bus_valid      = 1'b1;
        i_bus_access     = 2'b10;
        i_bus_address    = 8'h3C;
        i_bus_write_data = 32'h0;
        i_bus_strobe     = 4'hF;
        @(negedge i_clk);
        i_bus_valid = 1'b0;
        @(negedge i_clk);
        check("arst_in_wait", {62'd0, o_wb_cyc, o_wb_stb}, 64'b10);
        i_wb_stall = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_cyc_stb_ready", {61'd0, o_wb_cyc, o_wb_stb, o_bus_ready}, 64'd0);
        check("arst_adr", 64'(o_wb_adr), 64'd0);
        @(negedge i_clk);
        i_wb_stall = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_txn("post_rst", 1'b0, 8'h08, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 1, 0, 2, 3);

`ifdef RGGEN_WB_MASTER_TIMEOUT_EN
        run_txn("tmo_none", 1'b0, 8'h40, 32'h0, 4'hF, 0, 0, 2, 0, 32'h00000077, 2'b11, 32'h0,        1, 0, 8, 9);
        run_txn("tmo_ack8", 1'b0, 8'h44, 32'h0, 4'hF, 0, 0, 0, 8, 32'h00000077, 2'b00, 32'h00000077, 1, 0, 8, 9);
`else
        run_txn("slow_ack", 1'b0, 8'h40, 32'h0, 4'hF, 0, 0, 0, 20, 32'h00000077, 2'b00, 32'h00000077, 1, 0, 20, 21);
`endif

        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rggen_wishbone_master_bridge.md
Name: rggen_wishbone_master_bridge

Overview:
Wishbone B4 pipelined initiator. Accepts single register accesses on the simple rggen-style request bus (valid/access/address/write_data/strobe in; ready/status/read_data out) and issues each as one Wishbone classic-pipelined cycle. Used by control-path masters (command decoder, debug UART) to reach rggen register blocks through their Wishbone adapters. One outstanding transaction at a time; responses to the request side are registered.

Parameters:
ADDRESS_WIDTH, 8, width of request and Wishbone address
BUS_WIDTH, 32, data width; byte lanes = BUS_WIDTH/8
MAX_RETRY, 3, number of reissues after i_wb_rty before reporting SLVERR (0 = no reissue)
TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_bus_valid  in  1  request valid; held until o_bus_ready
i_bus_access  in  2  bit1=1 for a valid access, bit0=1 write / 0 read
i_bus_address  in  ADDRESS_WIDTH  byte address
i_bus_write_data  in  BUS_WIDTH  write data
i_bus_strobe  in  BUS_WIDTH/8  byte enables
o_bus_ready  out  1  one-cycle completion pulse
o_bus_status  out  2  00 OKAY, 10 SLVERR, 11 timeout; valid with o_bus_ready
o_bus_read_data  out  BUS_WIDTH  read data; valid with o_bus_ready
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
i_wb_stall  in  1  slave stall
o_wb_adr  out  ADDRESS_WIDTH  address
o_wb_we  out  1  write enable
o_wb_dat  out  BUS_WIDTH  write data
o_wb_sel  out  BUS_WIDTH/8  byte select
i_wb_ack  in  1  normal termination
i_wb_err  in  1  error termination
i_wb_rty  in  1  retry termination
i_wb_dat  in  BUS_WIDTH  read data

Behaviour:
- Single clock i_clk; asynchronous active-low reset i_rst_n. Reset forces all outputs to 0, state IDLE, retry and timeout counters 0, immediately and regardless of state (including mid-cycle).
- All outputs are registered.
- FSM states: IDLE, STB, WAIT, GAP, RESP.
- IDLE: o_wb_cyc=o_wb_stb=0. On i_bus_valid=1, latch address/we(=access[0])/data/strobe into the o_wb_* registers and enter STB. o_wb_cyc and o_wb_stb rise the next cycle.
- STB: cyc=1, stb=1, request fields held constant. If i_wb_stall=0, the request is accepted: enter WAIT with stb=0 and cyc=1. If i_wb_stall=1, stay in STB.
- Termination: ack/err/rty are sampled only while cyc=1 in STB (accept cycle) or WAIT. Priority is err > ack > rty if more than one is asserted.
  - ack: capture i_wb_dat (reads; write responses carry 0), status=00, enter RESP. Drop cyc the same edge.
  - err: status=10, read data 0, enter RESP.
  - rty with retry count < MAX_RETRY: increment the count and enter GAP. GAP holds cyc=0 for one cycle, then enters STB and reissues the latched request.
  - rty with retry count = MAX_RETRY: status=10, enter RESP.
- RESP: o_bus_ready=1 for exactly one cycle, with o_bus_status and o_bus_read_data valid. Then return to IDLE and clear the retry count. o_bus_read_data holds its value until the next completion.
- i_bus_valid is ignored outside IDLE. A request still high in the cycle after RESP is treated as a new request.
- Minimum latency: valid sampled at edge N; cyc/stb high after N; accept at N+1; ack at N+2 sets ready high after N+3 for one cycle.
- Unsolicited ack/err/rty while cyc=0 is ignored.

Optional Feature:
RGGEN_WB_MASTER_TIMEOUT_EN.
- Defined: a counter runs while cyc=1. It clears on entry to STB from IDLE or GAP and saturates at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES with no termination, cyc and stb drop next edge, status=11, read data 0, enter RESP. A termination arriving in the same cycle as expiry wins.
- Undefined: no counter logic; the bridge waits indefinitely; status 11 is never produced.

Test Plan:
- Read 0x10, no stall, slave acks next cycle with 0xDEADBEEF -> cyc high 2 cycles; ready pulses once, status 00, read_data 0xDEADBEEF, 3 cycles after valid.
- Write 0x24 data 0x12345678 strobe 0x3, stall held 4 cycles -> stb held for 5 cycles with adr/dat/sel/we stable; ready after ack with status 00.
- Read, slave asserts rty 3 times then ack with 0xA5 (MAX_RETRY=3) -> 3 GAP cycles with cyc=0, 4 strobes total, status 00, data 0xA5. Repeat with a 4th rty -> status 10 after 4 strobes.
- Slave asserts err and ack together -> status 10, read_data 0.
- i_rst_n low while in WAIT with stall -> cyc/stb/ready go 0 asynchronously; after release the next request starts cleanly from IDLE.
- With RGGEN_WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> cyc drops, ready with status 11; ack on the 8th cycle -> status 00 instead.
